router_1x3: RTL and testbench

Single-input, three-output byte-wide packet router with per-port output FIFOs. Packets arrive on `datain` framed by `packet_valid`. Each packet is steered to one of three 16-deep output FIFOs by the address in its header byte, and its trailing parity byte is checked. It is the top level of the router subsystem, sitting between the upstream packet source and three downstream consumers, which drain their ports with per-port read enables.

---
 rtl/router_1x3.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_router_1x3.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_1x3.sv
// router_1x3: single-input, three-output byte packet router.
// Each packet is steered by its header address into one of three 16-deep
// output FIFOs; the trailing parity byte is stored and checked.

// 16 x 9-bit output FIFO with registered read data and idle-flush timer.
module router_fifo (
   input  logic       clk,
   input  logic       resetn,
   input  logic       write_enb,
   input  logic [8:0] write_data,
   input  logic       read_enb,
   output logic [7:0] data_out,
   output logic       vldout,
   output logic       full,
   output logic       soft_rst
);
   logic [8:0] mem [16];
   logic [3:0] wr_ptr;
   logic [3:0] rd_ptr;
   logic [4:0] count;
   logic [4:0] idle_cnt;
   logic       do_wr;
   logic       do_rd;
   logic [8:0] rd_word;
   logic       unused_hdr_bit;

   assign vldout   = (count != 5'd0);
   assign full     = (count == 5'd16);
   // 30th consecutive cycle with data waiting and nobody reading
   assign soft_rst = vldout && !read_enb && (idle_cnt == 5'd29);
   assign do_wr    = write_enb && !full;
   assign do_rd    = read_enb && vldout;
   assign rd_word  = mem[rd_ptr];
   // header marker is kept in storage but the read port is byte-wide
   assign unused_hdr_bit = rd_word[8];

   // storage array, no reset needed: occupancy tracking guards every read
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= write_data;
      end
   end

   // pointers, occupancy and read register; a soft reset flushes them all
   always_ff @(posedge clk) begin
      if (resetn || soft_rst) begin
         wr_ptr   <= 4'd0;
         rd_ptr   <= 4'd0;
         count    <= 5'd0;
         data_out <= 8'd0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 4'd1;
         end
         if (do_rd) begin
            rd_ptr   <= rd_ptr + 4'd1;
            data_out <= rd_word[7:0];
         end
         if (do_wr && !do_rd) begin
            count <= count + 5'd1;
         end else if (do_rd && !do_wr) begin
            count <= count - 5'd1;
         end
      end
   end

   // idle timer: counts unread cycles while data is waiting
   always_ff @(posedge clk) begin
      if (resetn || soft_rst) begin
         idle_cnt <= 5'd0;
      end else if (vldout && !read_enb) begin
         idle_cnt <= idle_cnt + 5'd1;
      end else begin
         idle_cnt <= 5'd0;
      end
   end
endmodule

// state       | meaning
// ------------+---------------------------------------------------------
// DECODE      | idle, waiting for a header with a legal address
// WAIT_EMPTY  | header latched, target FIFO still holds an older packet
// LOAD_FIRST  | write latched header word (bit 8 set)
// LOAD_DATA   | stream payload bytes into the target FIFO
// FULL        | target FIFO full, one byte parked in the hold register
// AFTER_FULL  | write the parked byte once space is available
// LOAD_PARITY | write the received parity byte
// CHECK       | compare computed and received parity, update err
module router_1x3 (
   input  logic       clk,
   input  logic       resetn,
   input  logic       packet_valid,
   input  logic [7:0] datain,
   input  logic       read_enb_0,
   input  logic       read_enb_1,
   input  logic       read_enb_2,
   output logic [7:0] data_out_0,
   output logic [7:0] data_out_1,
   output logic [7:0] data_out_2,
   output logic       vldout_0,
   output logic       vldout_1,
   output logic       vldout_2,
   output logic       busy,
   output logic       err
);
   typedef enum logic [2:0] {
      DECODE,
      WAIT_EMPTY,
      LOAD_FIRST,
      LOAD_DATA,
      FULL,
      AFTER_FULL,
      LOAD_PARITY,
      CHECK
   } state_t;

   state_t     state;
   state_t     next_state;
   logic [7:0] hdr_reg;
   logic [1:0] addr_reg;
   logic [7:0] hold_reg;
   logic       hold_par;
   logic [7:0] parity_int;
   logic [7:0] rx_parity;
   logic       wr_en;
   logic [8:0] wr_data;
   logic       full_0, full_1, full_2;
   logic       srst_0, srst_1, srst_2;
   logic [3:0] empty_vec;
   logic [3:0] full_vec;
   logic [3:0] srst_vec;
   logic       tgt_empty;
   logic       tgt_full;
   logic       abort;
   logic       hdr_accept;

   // address 3 has no FIFO: it reads as "not empty, not full, no flush"
   assign empty_vec  = {1'b0, !vldout_2, !vldout_1, !vldout_0};
   assign full_vec   = {1'b0, full_2, full_1, full_0};
   assign srst_vec   = {1'b0, srst_2, srst_1, srst_0};
   assign tgt_empty  = empty_vec[addr_reg];
   assign tgt_full   = full_vec[addr_reg];
   assign abort      = (state != DECODE) && srst_vec[addr_reg];
   assign hdr_accept = (state == DECODE) && packet_valid && (datain[1:0] != 2'd3);

   // state register
   always_ff @(posedge clk) begin
      if (resetn) begin
         state <= DECODE;
      end else begin
         state <= next_state;
      end
   end

   // next-state, busy and FIFO write request
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      wr_en      = 1'b0;
      wr_data    = 9'd0;
      case (state)
         DECODE: begin
            if (hdr_accept) begin
               next_state = empty_vec[datain[1:0]] ? LOAD_FIRST : WAIT_EMPTY;
            end
         end
         WAIT_EMPTY: begin
            busy = 1'b1;
            if (tgt_empty) begin
               next_state = LOAD_FIRST;
            end
         end
         LOAD_FIRST: begin
            busy       = 1'b1;
            wr_en      = 1'b1;
            wr_data    = {1'b1, hdr_reg};
            next_state = LOAD_DATA;
         end
         LOAD_DATA: begin
            if (tgt_full) begin
               next_state = FULL;
            end else if (packet_valid) begin
               wr_en   = 1'b1;
               wr_data = {1'b0, datain};
            end else begin
               next_state = LOAD_PARITY;
            end
         end
         FULL: begin
            busy = 1'b1;
            if (!tgt_full) begin
               next_state = AFTER_FULL;
            end
         end
         AFTER_FULL: begin
            busy    = 1'b1;
            wr_en   = 1'b1;
            wr_data = {1'b0, hold_reg};
            // a parked parity byte is the end of the packet already
            if (hold_par) begin
               next_state = CHECK;
            end else if (packet_valid) begin
               next_state = LOAD_DATA;
            end else begin
               next_state = LOAD_PARITY;
            end
         end
         LOAD_PARITY: begin
            busy = 1'b1;
            // only reachable full right after AFTER_FULL refilled the FIFO
            if (!tgt_full) begin
               wr_en      = 1'b1;
               wr_data    = {1'b0, rx_parity};
               next_state = CHECK;
            end
         end
         CHECK: begin
            busy       = 1'b1;
            next_state = DECODE;
         end
         default: begin
            next_state = DECODE;
         end
      endcase
      if (abort) begin
         next_state = DECODE;
         wr_en      = 1'b0;
      end
   end

   // header latch, hold register, parity accumulation and error flag
   always_ff @(posedge clk) begin
      if (resetn) begin
         hdr_reg    <= 8'd0;
         addr_reg   <= 2'd0;
         hold_reg   <= 8'd0;
         hold_par   <= 1'b0;
         parity_int <= 8'd0;
         rx_parity  <= 8'd0;
         err        <= 1'b0;
      end else begin
         if (hdr_accept) begin
            hdr_reg  <= datain;
            addr_reg <= datain[1:0];
            err      <= 1'b0;
         end
         case (state)
            LOAD_FIRST: begin
               parity_int <= hdr_reg;
            end
            LOAD_DATA: begin
               if (tgt_full) begin
                  hold_reg <= datain;
                  hold_par <= !packet_valid;
                  if (!packet_valid) begin
                     rx_parity <= datain;
                  end
               end else if (packet_valid) begin
                  parity_int <= parity_int ^ datain;
               end else begin
                  rx_parity <= datain;
               end
            end
            AFTER_FULL: begin
               if (!hold_par) begin
                  parity_int <= parity_int ^ hold_reg;
                  if (!packet_valid) begin
                     rx_parity <= datain;
                  end
               end
            end
            CHECK: begin
               if (!abort) begin
                  err <= (parity_int != rx_parity);
               end
            end
            default: begin
            end
         endcase
      end
   end

   router_fifo u_fifo_0 (
      .clk        (clk),
      .resetn     (resetn),
      .write_enb  (wr_en && (addr_reg == 2'd0)),
      .write_data (wr_data),
      .read_enb   (read_enb_0),
      .data_out   (data_out_0),
      .vldout     (vldout_0),
      .full       (full_0),
      .soft_rst   (srst_0)
   );

   router_fifo u_fifo_1 (
      .clk        (clk),
      .resetn     (resetn),
      .write_enb  (wr_en && (addr_reg == 2'd1)),
      .write_data (wr_data),
      .read_enb   (read_enb_1),
      .data_out   (data_out_1),
      .vldout     (vldout_1),
      .full       (full_1),
      .soft_rst   (srst_1)
   );

   router_fifo u_fifo_2 (
      .clk        (clk),
      .resetn     (resetn),
      .write_enb  (wr_en && (addr_reg == 2'd2)),
      .write_data (wr_data),
      .read_enb   (read_enb_2),
      .data_out   (data_out_2),
      .vldout     (vldout_2),
      .full       (full_2),
      .soft_rst   (srst_2)
   );
endmodule

// File: tb/tb_router_1x3.sv
// Bench for router_1x3: packet-level reference model (per-port expected
// word queues plus expected parity flag) against randomized traffic.
module tb_router_1x3;
   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic       packet_valid = 1'b0;
   logic [7:0] datain = 8'd0;
   logic       read_enb_0 = 1'b0;
   logic       read_enb_1 = 1'b0;
   logic       read_enb_2 = 1'b0;
   logic [7:0] data_out_0, data_out_1, data_out_2;
   logic       vldout_0, vldout_1, vldout_2;
   logic       busy, err;

   router_1x3 dut (
      .clk          (clk),
      .resetn       (resetn),
      .packet_valid (packet_valid),
      .datain       (datain),
      .read_enb_0   (read_enb_0),
      .read_enb_1   (read_enb_1),
      .read_enb_2   (read_enb_2),
      .data_out_0   (data_out_0),
      .data_out_1   (data_out_1),
      .data_out_2   (data_out_2),
      .vldout_0     (vldout_0),
      .vldout_1     (vldout_1),
      .vldout_2     (vldout_2),
      .busy         (busy),
      .err          (err)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_q [3][$];
   logic [2:0] rd_on = 3'b000;
   logic       rd_rand = 1'b0;
   logic [2:0] pend = 3'b000;
   logic [7:0] pend_val [3];
   int         pops [3] = '{0, 0, 0};
   logic       exp_err = 1'b0;
   logic [2:0] mon_re;
   logic [2:0] mon_vld;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] dout_of(input int p);
      case (p)
         0:       return data_out_0;
         1:       return data_out_1;
         default: return data_out_2;
      endcase
   endfunction

   function automatic logic vld_of(input int p);
      case (p)
         0:       return vldout_0;
         1:       return vldout_1;
         default: return vldout_2;
      endcase
   endfunction

   // reader + scoreboard: compare last cycle's pops, then issue this cycle's reads
   always @(negedge clk) begin
      for (int p = 0; p < 3; p++) begin
         if (pend[p]) begin
            check_val($sformatf("rd_data%0d", p), {24'd0, dout_of(p)}, {24'd0, pend_val[p]});
            pend[p] = 1'b0;
         end
      end
      mon_vld = {vldout_2, vldout_1, vldout_0};
      for (int p = 0; p < 3; p++) begin
         mon_re[p] = rd_on[p] && (!rd_rand || ($urandom_range(3) != 0));
      end
      read_enb_0 = mon_re[0];
      read_enb_1 = mon_re[1];
      read_enb_2 = mon_re[2];
      for (int p = 0; p < 3; p++) begin
         if (mon_re[p] && mon_vld[p]) begin
            if (exp_q[p].size() == 0) begin
               check_val($sformatf("rd_extra%0d", p), 32'd1, 32'd0);
            end else begin
               pend_val[p] = exp_q[p].pop_front();
               pend[p]     = 1'b1;
               pops[p]++;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // present one byte and hold it until a non-busy cycle consumes it
   task automatic drive_byte(input logic [7:0] b, input logic pv);
      int g = 0;
      datain       = b;
      packet_valid = pv;
      while (busy && g < 300) begin
         tick();
         g++;
      end
      if (busy) check_val("drive_stall", {31'd0, busy}, 32'd0);
      tick();
   endtask

   task automatic send_pkt(input logic [1:0] dest, input int len, input bit corrupt);
      logic [7:0] hdr;
      logic [7:0] par;
      logic [7:0] b;
      hdr = {len[5:0], dest};
      par = hdr;
      exp_q[dest].push_back(hdr);
      drive_byte(hdr, 1'b1);
      for (int i = 0; i < len; i++) begin
         b   = 8'($urandom);
         par = par ^ b;
         exp_q[dest].push_back(b);
         drive_byte(b, 1'b1);
      end
      if (corrupt) par = par ^ 8'h01;
      exp_q[dest].push_back(par);
      drive_byte(par, 1'b0);
      datain       = 8'd0;
      packet_valid = 1'b0;
      exp_err      = corrupt;
   endtask

   task automatic wait_idle();
      int g = 0;
      while (busy && g < 300) begin
         tick();
         g++;
      end
      if (busy) check_val("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic drain(input int p, input int limit);
      int g = 0;
      rd_on[p] = 1'b1;
      while ((exp_q[p].size() != 0 || pend[p]) && g < limit) begin
         tick();
         g++;
      end
      rd_on[p] = 1'b0;
      check_val($sformatf("drain_left%0d", p), exp_q[p].size(), 32'd0);
      check_val($sformatf("drain_vld%0d", p), {31'd0, vld_of(p)}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int dst;
      int len;
      bit cor;

      // reset
      repeat (3) tick();
      resetn = 1'b0;
      tick();
      check_val("rst_dout0", {24'd0, data_out_0}, 32'd0);
      check_val("rst_dout1", {24'd0, data_out_1}, 32'd0);
      check_val("rst_dout2", {24'd0, data_out_2}, 32'd0);
      check_val("rst_vld", {29'd0, vldout_2, vldout_1, vldout_0}, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_err", {31'd0, err}, 32'd0);

      // header 0x21: 8 bytes to port 1, then 30 read cycles
      base = pops[1];
      send_pkt(2'd1, 8, 1'b0);
      wait_idle();
      check_val("a_err", {31'd0, err}, {31'd0, exp_err});
      rd_on[1] = 1'b1;
      repeat (30) tick();
      rd_on[1] = 1'b0;
      check_val("a_pops", pops[1] - base, 32'd10);
      check_val("a_vld", {31'd0, vldout_1}, 32'd0);

      // same packet, only 5 reads, then idle flush after 30 unread cycles
      base = pops[1];
      send_pkt(2'd1, 8, 1'b0);
      wait_idle();
      check_val("b_err", {31'd0, err}, 32'd0);
      rd_on[1] = 1'b1;
      repeat (5) tick();
      rd_on[1] = 1'b0;
      tick();
      for (int k = 1; k < 30; k++) begin
         tick();
         check_val($sformatf("b_hold%0d", k), {31'd0, vldout_1}, 32'd1);
      end
      tick();
      check_val("b_flush_vld", {31'd0, vldout_1}, 32'd0);
      check_val("b_flush_dout", {24'd0, data_out_1}, 32'd0);
      check_val("b_pops", pops[1] - base, 32'd5);
      exp_q[1].delete();

      // header 0x16: 5 bytes to port 2, good parity
      rd_rand = 1'b1;
      base = pops[2];
      send_pkt(2'd2, 5, 1'b0);
      wait_idle();
      check_val("c_err", {31'd0, err}, 32'd0);
      drain(2, 200);
      check_val("c_pops", pops[2] - base, 32'd7);

      // same with corrupted parity
      base = pops[2];
      send_pkt(2'd2, 5, 1'b1);
      wait_idle();
      check_val("d_err", {31'd0, err}, 32'd1);
      drain(2, 200);
      check_val("d_pops", pops[2] - base, 32'd7);
      check_val("d_err_held", {31'd0, err}, 32'd1);

      // next header clears err; second packet to a non-empty FIFO waits
      rd_rand = 1'b0;
      base = pops[0];
      send_pkt(2'd0, 3, 1'b0);
      check_val("e_err_clear", {31'd0, err}, 32'd0);
      fork
         send_pkt(2'd0, 2, 1'b0);
         begin
            repeat (5) tick();
            check_val("e_wait_busy", {31'd0, busy}, 32'd1);
            check_val("e_wait_vld", {31'd0, vldout_0}, 32'd1);
            repeat (4) tick();
            check_val("e_wait_busy2", {31'd0, busy}, 32'd1);
            rd_on[0] = 1'b1;
         end
      join
      wait_idle();
      check_val("e_err", {31'd0, err}, 32'd0);
      drain(0, 200);
      check_val("e_pops", pops[0] - base, 32'd9);

      // 20-byte payload with no reads: FIFO fills, FSM stalls, then resumes
      base = pops[2];
      fork
         send_pkt(2'd2, 20, 1'b0);
         begin
            repeat (22) tick();
            check_val("f_full_busy", {31'd0, busy}, 32'd1);
            check_val("f_full_vld", {31'd0, vldout_2}, 32'd1);
            rd_on[2] = 1'b1;
         end
      join
      wait_idle();
      check_val("f_err", {31'd0, err}, 32'd0);
      drain(2, 300);
      check_val("f_pops", pops[2] - base, 32'd22);

      // randomized traffic with random read gaps
      rd_rand = 1'b1;
      rd_on   = 3'b111;
      for (int n = 0; n < 20; n++) begin
         repeat ($urandom_range(2)) tick();
         if ($urandom_range(3) == 0) begin
            datain       = {6'($urandom), 2'b11};
            packet_valid = 1'b1;
            tick();
            check_val("r_junk_busy", {31'd0, busy}, 32'd0);
            check_val("r_junk_err", {31'd0, err}, {31'd0, exp_err});
            packet_valid = 1'b0;
         end
         dst = $urandom_range(2);
         len = $urandom_range(63, 1);
         cor = ($urandom_range(3) == 0);
         send_pkt(2'(dst), len, cor);
         wait_idle();
         check_val($sformatf("r_err%0d", n), {31'd0, err}, {31'd0, exp_err});
      end
      rd_on = 3'b000;
      for (int p = 0; p < 3; p++) begin
         drain(p, 500);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
